ccx_ic_arbiter: RTL
===================

Name: ccx_ic_arbiter

Overview:
Two-into-one core-complex interconnect arbiter. It merges the CPU instruction-fetch and data memory buses onto the single core_mem_bus that feeds the interconnect router's if_core port. It adds zero latency on the request path and tracks which requester owns each outstanding response. Arbitration is round-robin or fixed data-priority, with a request lock so a stalled request is never swapped out before it is granted.

Parameters:
AW, 39, address width (matches router)
DW, 64, data width (matches router)
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, data port wins

Ports:
g_clk  input  1  clock
g_resetn  input  1  reset; asynchronous, active-low
if_imem  core_mem_bus.RSP  bus  CPU instruction-fetch requester
if_dmem  core_mem_bus.RSP  bus  CPU data requester
if_out  core_mem_bus.REQ  bus  merged request; connects to router if_core

Behaviour:
- Clock and reset: one clock, g_clk. Reset g_resetn is asynchronous, active-low.
- Bus rules:
  - A transfer completes when req && gnt in the same cycle.
  - rdata/err for that transfer are valid in the following cycle.
  - A requester holds req and all request fields stable until it is granted.
- State registers (all cleared asynchronously on !g_resetn):
  - lock_vld = 0, lock_sel = 0 (0 = imem, 1 = dmem)
  - last_sel = 1
  - rsp_i = 0, rsp_d = 0
- Selection (combinational, each cycle):
  - lock_vld && req of lock_sel port high: sel = lock_sel.
  - Else, only one req high: sel = that port.
  - Else, both high: RR_EN=1 gives sel = !last_sel; RR_EN=0 gives sel = dmem.
  - Neither high: sel = last_sel; value is don't-care.
- Request path:
  - if_out.req = if_imem.req || if_dmem.req.
  - addr, wen, strb, wdata, prv, rtype are muxed from sel.
- Grant path:
  - if_imem.gnt = if_out.gnt && if_imem.req && sel==0.
  - if_dmem.gnt = if_out.gnt && if_dmem.req && sel==1.
  - The unselected port sees gnt = 0.
- Lock register updates:
  - if_out.req && !if_out.gnt: lock_vld <= 1, lock_sel <= sel.
  - if_out.req && if_out.gnt: lock_vld <= 0.
  - Locked port drops req without a grant (protocol violation): lock ignored that cycle, free arbitration applies, lock_vld <= 0 unless the new request also stalls.
- last_sel <= sel on every completed transfer.
- Response tracking:
  - rsp_i <= if_imem.req && if_imem.gnt.
  - rsp_d <= if_dmem.req && if_dmem.gnt.
  - Both update every cycle; at most one is set.
- Response path:
  - if_imem.rdata = if_dmem.rdata = if_out.rdata (broadcast).
  - if_imem.err = rsp_i && if_out.err.
  - if_dmem.err = rsp_d && if_out.err.
  - A port with no outstanding response sees err = 0.
- Throughput and latency:
  - One transfer per cycle sustained.
  - Alternating grants under continuous contention when RR_EN=1.
  - Zero added latency on request, grant and response.
- Reset:
  - No output is gated by reset; requesters hold req low in reset.
  - err outputs are 0 from reset until the first completed transfer.
- Reset mid-operation: lock and response tracking are lost. A response arriving the cycle after reset deassertion is not reported as err on either port.

Test Plan:
- Reset, then imem only: req addr 0x0000000010, out gnt=1. Expect if_out.addr=0x10, imem gnt=1, dmem gnt=0. Next cycle rdata=0xDEAD_BEEF reaches imem with err=0.
- Both req every cycle, RR_EN=1, out gnt=1 for 4 cycles. Grant order imem, dmem, imem, dmem; if_out.addr alternates accordingly.
- Both req, RR_EN=0, out gnt=1 for 3 cycles. dmem granted all 3 cycles, imem gnt=0 throughout.
- Lock: imem selected, out gnt=0 for 3 cycles, dmem raises req in cycle 2. if_out fields stay imem's until gnt; imem is granted in cycle 4, dmem in cycle 5.
- Error routing: dmem write to unmapped address 0x4000000000, router returns err=1 next cycle. dmem err=1 and imem err=0.
- Async reset asserted while lock_vld=1 and rsp_d=1, off a clock edge. All state clears immediately and both err outputs read 0; after release, the first contention grants imem.

Source files
------------

// File: rtl/ccx_ic_arbiter_if.sv
// Core memory bus between a requester (REQ side) and a responder (RSP side).
// Transfer completes on req && gnt; rdata/err are valid the following cycle.
interface core_mem_bus #(
    parameter int unsigned AW = 39,
    parameter int unsigned DW = 64
);
    localparam int unsigned SW = DW / 8;

    logic          req;
    logic          gnt;
    logic [AW-1:0] addr;
    logic          wen;
    logic [SW-1:0] strb;
    logic [DW-1:0] wdata;
    logic [1:0]    prv;
    logic [1:0]    rtype;
    logic [DW-1:0] rdata;
    logic          err;

    modport REQ (output req, addr, wen, strb, wdata, prv, rtype,
                 input  gnt, rdata, err);
    modport RSP (input  req, addr, wen, strb, wdata, prv, rtype,
                 output gnt, rdata, err);
endinterface

// File: rtl/ccx_ic_arbiter.sv
// Merges the instruction-fetch and data buses onto one core_mem_bus with zero
// added latency, a stall lock, and per-port response ownership tracking.
module ccx_ic_arbiter #(
    parameter int unsigned AW    = 39,
    parameter int unsigned DW    = 64,
    parameter bit          RR_EN = 1'b1
) (
    input  logic     g_clk,
    input  logic     g_resetn,
    core_mem_bus.RSP if_imem,
    core_mem_bus.RSP if_dmem,
    core_mem_bus.REQ if_out
);
    localparam int unsigned SW    = DW / 8;
    localparam logic        SEL_I = 1'b0;
    localparam logic        SEL_D = 1'b1;

    logic          lock_vld;
    logic          lock_sel;
    logic          last_sel;
    logic          rsp_i;
    logic          rsp_d;

    logic          sel_c;
    logic          req_c;
    logic          gnt_i_c;
    logic          gnt_d_c;
    logic [AW-1:0] addr_c;
    logic [SW-1:0] strb_c;
    logic [DW-1:0] wdata_c;

    // Requester selection; a held lock only applies while its owner still requests.
    always_comb begin
        sel_c = last_sel;
        if (lock_vld && (lock_sel ? if_dmem.req : if_imem.req)) begin
            sel_c = lock_sel;
        end else if (if_imem.req && if_dmem.req) begin
            sel_c = RR_EN ? ~last_sel : SEL_D;
        end else if (if_imem.req) begin
            sel_c = SEL_I;
        end else if (if_dmem.req) begin
            sel_c = SEL_D;
        end
    end

    assign req_c   = if_imem.req || if_dmem.req;
    assign gnt_i_c = if_out.gnt && if_imem.req && (sel_c == SEL_I);
    assign gnt_d_c = if_out.gnt && if_dmem.req && (sel_c == SEL_D);
    assign addr_c  = sel_c ? if_dmem.addr  : if_imem.addr;
    assign strb_c  = sel_c ? if_dmem.strb  : if_imem.strb;
    assign wdata_c = sel_c ? if_dmem.wdata : if_imem.wdata;

    assign if_out.req   = req_c;
    assign if_out.addr  = addr_c;
    assign if_out.wen   = sel_c ? if_dmem.wen   : if_imem.wen;
    assign if_out.strb  = strb_c;
    assign if_out.wdata = wdata_c;
    assign if_out.prv   = sel_c ? if_dmem.prv   : if_imem.prv;
    assign if_out.rtype = sel_c ? if_dmem.rtype : if_imem.rtype;

    assign if_imem.gnt = gnt_i_c;
    assign if_dmem.gnt = gnt_d_c;

    // Read data is broadcast; err is steered to the owner of the outstanding response.
    assign if_imem.rdata = if_out.rdata;
    assign if_dmem.rdata = if_out.rdata;
    assign if_imem.err   = rsp_i && if_out.err;
    assign if_dmem.err   = rsp_d && if_out.err;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lock_vld <= 1'b0;
            lock_sel <= SEL_I;
            last_sel <= SEL_D;
            rsp_i    <= 1'b0;
            rsp_d    <= 1'b0;
        end else begin
            lock_vld <= req_c && !if_out.gnt;
            if (req_c && !if_out.gnt) begin
                lock_sel <= sel_c;
            end
            if (req_c && if_out.gnt) begin
                last_sel <= sel_c;
            end
            rsp_i <= gnt_i_c;
            rsp_d <= gnt_d_c;
        end
    end
endmodule
